// File: rtl/sw_input_stage.sv
// Switch front end for the picoMIPS input port: synchronises the switches, debounces the enable
// and offers one captured operand per press over valid/ack. Define SW_INPUT_DEBOUNCE_EN for the counter debouncer.
module sw_input_stage #(
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 4096
) (
    input  logic             fastclk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             sw_en,
    input  logic             in_ack,
    output logic             in_valid,
    output logic [WIDTH-1:0] in_data,
    output logic             sw_en_db,
    output logic             busy
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OFFER   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    logic             en_meta_q;
    logic             en_s_q;
    logic [WIDTH-1:0] data_meta_q;
    logic [WIDTH-1:0] data_s_q;
    logic             db;
    logic             db_dly_q;
    logic             rise;
    state_t           state_q;
    logic             in_valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] in_data_q;

    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            en_meta_q   <= 1'b0;
            en_s_q      <= 1'b0;
            data_meta_q <= '0;
            data_s_q    <= '0;
        end else begin
            en_meta_q   <= sw_en;
            en_s_q      <= en_meta_q;
            data_meta_q <= sw_data;
            data_s_q    <= data_meta_q;
        end
    end

`ifdef SW_INPUT_DEBOUNCE_EN
    localparam logic [15:0] CNT_LAST = 16'(DB_CYCLES - 1);

    logic        db_q;
    logic        db_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Counter restarts whenever the input agrees with db and after every flip, so it never wraps.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (en_s_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = en_s_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign db = db_q;
`else
    assign db = en_s_q;
`endif

    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            db_dly_q <= 1'b0;
        end else begin
            db_dly_q <= db;
        end
    end

    assign rise = db & ~db_dly_q;

    // Operand register is loaded only on IDLE->OFFER; RELEASE forces a full release before the next capture.
    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            in_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            in_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        in_data_q  <= data_s_q;
                        state_q    <= OFFER;
                        in_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                OFFER: begin
                    if (in_ack) begin
                        state_q    <= RELEASE;
                        in_valid_q <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!db) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_valid = in_valid_q;
    assign in_data  = in_data_q;
    assign busy     = busy_q;
    assign sw_en_db = db;

endmodule

// File: tb/tb_sw_input_stage.sv
// Self-checking bench for sw_input_stage: directed scenarios plus random switch activity,
// compared every cycle against a sample-history model of the switch input stage.
module tb_sw_input_stage;
    localparam int W  = 8;
    localparam int DB = 16;
`ifdef SW_INPUT_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    localparam int LAT = DB_EN ? DB : 0;

    logic         fastclk = 1'b0;
    logic         reset   = 1'b1;
    logic [W-1:0] sw_data = '0;
    logic         sw_en   = 1'b0;
    logic         in_ack  = 1'b0;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         sw_en_db;
    logic         busy;

    int checks = 0;
    int errors = 0;

    sw_input_stage #(.WIDTH(W), .DB_CYCLES(DB)) dut (
        .fastclk (fastclk),
        .reset   (reset),
        .sw_data (sw_data),
        .sw_en   (sw_en),
        .in_ack  (in_ack),
        .in_valid(in_valid),
        .in_data (in_data),
        .sw_en_db(sw_en_db),
        .busy    (busy)
    );

    always #5 fastclk = ~fastclk;

    // Model: raw inputs seen at each edge since reset; db is derived from that history.
    bit           x_q[$];
    logic [W-1:0] d_q[$];
    bit           m_db, m_dbq;
    int           m_ph;          // 0 idle, 1 offering, 2 waiting for release
    logic [W-1:0] m_data;

    function automatic bit xh(input int k);
        if (k < 1) return 1'b0;
        return x_q[k-1];
    endfunction

    function automatic logic [W-1:0] dh(input int k);
        if (k < 1) return '0;
        return d_q[k-1];
    endfunction

    task automatic model_reset();
        x_q.delete();
        d_q.delete();
        m_db = 0; m_dbq = 0; m_ph = 0; m_data = '0;
    endtask

    task automatic model_step();
        bit old_db, old_rise, nd, all_mis;
        int n;
        old_db   = m_db;
        old_rise = m_db & ~m_dbq;
        x_q.push_back(sw_en);
        d_q.push_back(sw_data);
        n = x_q.size();
        case (m_ph)
            0: if (old_rise) begin m_data = dh(n - 2); m_ph = 1; end
            1: if (in_ack) m_ph = 2;
            default: if (!old_db) m_ph = 0;
        endcase
        // Synchronised level of edge j is the raw level of edge j-1; db flips after DB disagreeing samples.
        if (DB_EN) begin
            all_mis = 1'b1;
            for (int i = n - 1 - DB; i <= n - 2; i++)
                if (xh(i) == old_db) all_mis = 1'b0;
            nd = all_mis ? ~old_db : old_db;
        end else begin
            nd = xh(n - 1);
        end
        m_dbq = old_db;
        m_db  = nd;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge fastclk);
        model_step();
        #1;
        check("valid", 32'(in_valid), 32'(m_ph == 1));
        check("data",  32'(in_data),  32'(m_data));
        check("db",    32'(sw_en_db), 32'(m_db));
        check("busy",  32'(busy),     32'(m_ph != 0));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!in_valid && cnt < 500) begin tick(); cnt++; end
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 500) begin tick(); cnt++; end
    endtask

    task automatic do_ack();
        in_ack = 1'b1;
        tick();
        in_ack = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge fastclk);
        #3 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int cnt, vcount, dbcount, mv, mdb;
        logic [W-1:0] v;
        model_reset();
        #2;
        check("rst_valid", 32'(in_valid), 0);
        check("rst_data",  32'(in_data),  0);
        check("rst_db",    32'(sw_en_db), 0);
        check("rst_busy",  32'(busy),     0);
        release_reset();
        ticks(3);

        // Basic capture and release latency
        sw_data = 8'd2; sw_en = 1'b1;
        wait_valid(cnt);
        check("press_latency", 32'(cnt), 32'(3 + LAT));
        check("basic_data", 32'(in_data), 2);
        do_ack();
        check("ack_drop", 32'(in_valid), 0);
        check("busy_after_ack", 32'(busy), 1);
        ticks(5);
        sw_en = 1'b0;
        wait_idle(cnt);
        check("release_latency", 32'(cnt), 32'(3 + LAT));
        $display("basic capture: data=%0d release edges=%0d", in_data, cnt);

        // Bounce: toggle every 5 cycles for 100 cycles, then hold low
        vcount = 0; dbcount = 0; mv = 0; mdb = 0;
        in_ack = 1'b1;
        for (int i = 0; i < 100 + LAT + 6; i++) begin
            sw_en = (i < 100) ? ((i / 5) % 2 == 0) : 1'b0;
            tick();
            vcount  += int'(in_valid);  mv  += int'(m_ph == 1);
            dbcount += int'(sw_en_db);  mdb += int'(m_db);
        end
        in_ack = 1'b0;
        ticks(4);
        check("bounce_valids", 32'(vcount), 32'(mv));
        check("bounce_db", 32'(dbcount), 32'(mdb));
        $display("bounce: valid cycles=%0d db-high cycles=%0d", vcount, dbcount);

        // Data isolation
        sw_data = 8'd50; sw_en = 1'b1;
        wait_valid(cnt);
        sw_data = 8'd190;
        ticks(6);
        check("iso_hold", 32'(in_data), 50);
        do_ack();
        check("iso_after_ack", 32'(in_data), 50);
        sw_en = 1'b0;
        wait_idle(cnt);
        check("iso_idle_data", 32'(in_data), 50);
        sw_en = 1'b1;
        wait_valid(cnt);
        check("iso_repress", 32'(in_data), 190);
        $display("isolation: recapture data=%0d", in_data);
        do_ack();
        sw_en = 1'b0;
        wait_idle(cnt);

        // Hold without re-press
        sw_data = 8'($urandom); sw_en = 1'b1;
        wait_valid(cnt);
        do_ack();
        vcount = 0;
        for (int i = 0; i < 1000; i++) begin tick(); vcount += int'(in_valid); end
        check("hold_no_second", 32'(vcount), 0);
        sw_en = 1'b0;
        wait_idle(cnt);
        sw_data = 8'd254; sw_en = 1'b1;
        wait_valid(cnt);
        check("hold_new_data", 32'(in_data), 254);
        $display("hold: extra valid cycles=%0d new data=%0d", vcount, in_data);
        do_ack();
        sw_en = 1'b0;
        wait_idle(cnt);

        // Reset during OFFER, switch kept high
        sw_data = 8'd128; sw_en = 1'b1;
        wait_valid(cnt);
        check("offer_128", 32'(in_data), 128);
        reset = 1'b1;
        #1;
        check("async_valid", 32'(in_valid), 0);
        check("async_data",  32'(in_data),  0);
        check("async_busy",  32'(busy),     0);
        check("async_db",    32'(sw_en_db), 0);
        release_reset();
        wait_valid(cnt);
        check("post_reset_latency", 32'(cnt), 32'(3 + LAT));
        do_ack();
        vcount = 0;
        for (int i = 0; i < 3 * LAT + 20; i++) begin tick(); vcount += int'(in_valid); end
        check("post_reset_single", 32'(vcount), 0);
        $display("reset mid-offer: recapture after %0d edges", cnt);
        sw_en = 1'b0;
        wait_idle(cnt);

        // Random switch activity with random acks
        for (int s = 0; s < 250; s++) begin
            sw_en   = 1'($urandom);
            sw_data = 8'($urandom);
            v = 8'($urandom_range(1, 2 * DB + 4));
            for (int i = 0; i < int'(v); i++) begin
                in_ack = ($urandom_range(0, 3) == 0);
                tick();
            end
            if (s % 25 == 0)
                $display("random segment %0d: en=%0d valid=%0d data=%0d", s, sw_en, in_valid, in_data);
        end
        in_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
